contador_monitor: RTL and testbench
===================================

Name: contador_monitor

Overview:
- Synthesizable checker for the 16-bit mode counter (ENB, MODO, D, Q, RCO, Paridad); it is the observing end of the counter's interface, while the stimulus side drives it.
- Samples the counter's inputs and outputs on every rising CLK edge and predicts the next Q/RCO with a reference model.
- Flags Q, RCO and parity mismatches, and keeps error and check statistics.
- Sits beside the counter in the Tarea1 bench and in any later system that embeds the counter.

Parameters:
- WIDTH, 16, counter data width.
- PASO3, 3, increment applied in MODO=2'b10.
- ERR_W, 8, width of the saturating error counter.

Ports:
- CLK  input  1  rising-edge clock shared with the counter.
- RESET_L  input  1  asynchronous active-low reset.
- CLR  input  1  synchronous clear of ERR_CNT, CHK_CNT and ERR_STICKY; does not affect sync state.
- ENB  input  1  counter enable, as driven to the counter.
- MODO  input  2  counter mode, as driven to the counter.
- D  input  WIDTH  counter parallel-load data.
- Q  input  WIDTH  counter output.
- RCO  input  1  counter ripple carry out.
- Paridad  input  1  counter parity output.
- SYNC  output  1  model is locked and Q/RCO checks are active.
- ERR  output  1  one-cycle pulse on any detected mismatch.
- ERR_TIPO  output  3  mismatch kind, valid while ERR=1: bit0 Q, bit1 RCO, bit2 Paridad.
- ERR_STICKY  output  1  set by any ERR; cleared only by reset or CLR.
- ERR_CNT  output  ERR_W  saturating count of ERR pulses.
- CHK_CNT  output  16  saturating count of Q/RCO comparisons performed.
- Q_ESP  output  WIDTH  expected Q for the current comparison.

Behaviour:
- Reset (RESET_L=0, asynchronous): SYNC=0, ERR=0, ERR_TIPO=0, ERR_STICKY=0, ERR_CNT=0, CHK_CNT=0, Q_ESP=0, and all sample registers are 0. Reset mid-run discards the model; the monitor re-enters UNSYNC.
- Sampling: at each posedge the monitor registers ENB, MODO, D and Q as Qs, ENBs, MODOs and Ds.
- Counter model (the counter's contract):
  - ENB=0: Q holds, RCO=0.
  - ENB=1 and MODO=00: Q+1, RCO=1 iff Q was all-ones.
  - ENB=1 and MODO=01: Q-1, RCO=1 iff Q was 0.
  - ENB=1 and MODO=10: Q+PASO3 modulo 2^WIDTH, RCO=1 iff the sum overflowed.
  - ENB=1 and MODO=11: Q=D, RCO=0.
  - Paridad is always the XOR of all Q bits.
- Prediction: expected values are computed from Qs, ENBs, MODOs and Ds. They are compared against the Q and RCO sampled at the next posedge. Comparison results are registered, so ERR rises one cycle after the faulty value is sampled.
- Self-correction: the model always predicts from the observed Qs, not from its own previous prediction. A single corrupted Q therefore produces exactly one Q error, with no cascade.
- FSM:
  - UNSYNC: no Q/RCO checks. A sampled ENB=1 with MODO=11 moves the FSM to SYNC; the first comparison occurs at the next edge.
  - SYNC: a Q/RCO comparison is made every cycle, including ENB=0 hold cycles, and CHK_CNT increments on each. The FSM stays in SYNC until reset.
- Parity check: runs every cycle in both states and compares Paridad with the XOR of Q at the same sample.
- Error pulse: ERR=OR of the ERR_TIPO bits; several bits may be set in one cycle.
- Saturation: ERR_CNT saturates at all-ones and CHK_CNT at 16'hFFFF; neither wraps.
- CLR:
  - CLR=1 zeroes ERR_CNT, CHK_CNT and ERR_STICKY at the edge.
  - An ERR detected in the same cycle as CLR still pulses ERR but is not counted.
  - CLR has priority over increment.
- Wrap boundaries:
  - 16'hFFFF with MODO=00 predicts 0000 with RCO=1.
  - 0000 with MODO=01 predicts FFFF with RCO=1.
  - FFFE with MODO=10 predicts 0001 with RCO=1.
  - FFFC with MODO=10 predicts FFFF with RCO=0.
- X/Z values on D or Q are not interpreted; they compare as sampled.

Test Plan:
- Reset, then load D=0 (MODO=11), then MODO=00 for 15 cycles with a correct DUT → SYNC=1 one cycle after the load sample, Q_ESP steps 1..15, ERR never asserted, CHK_CNT=16.
- Load D=120, then MODO=01 for 15 cycles → Q_ESP 119..105, no ERR. Load 0, then MODO=01 → expected FFFF with RCO=1, no ERR against a correct DUT.
- Load FFFE, then MODO=10 → expected 0001 with RCO=1. Inject a DUT fault forcing RCO=0 → one ERR pulse, ERR_TIPO=3'b010, ERR_CNT=1, ERR_STICKY=1.
- Corrupt Q once (expected 0005, DUT shows 0007) → ERR_TIPO bit0 for one cycle only; the next cycle predicts from 0007 and gives no error. Flip Paridad on one sample → ERR_TIPO=3'b100.
- Hold ENB=0 for 4 cycles at Q=1234 → 4 clean comparisons with no RCO. Assert CLR while ERR_CNT=3 → ERR_CNT=0, ERR_STICKY=0, SYNC stays 1.
- Pull RESET_L low mid-count → all outputs are 0 immediately, with no comparisons until the next MODO=11 sample. Force 300 consecutive faults → ERR_CNT stops at 8'hFF.

Source files
------------

// File: rtl/contador_monitor.sv
// contador_monitor: passive checker for the 16-bit mode counter.
// It samples the counter's controls and outputs on every rising edge, predicts
// the next Q/RCO from what it observed, and reports mismatches together with
// error and comparison statistics.
module contador_monitor #(
  parameter int WIDTH = 16,
  parameter int PASO3 = 3,
  parameter int ERR_W = 8
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             CLR,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  input  logic             RCO,
  input  logic             Paridad,
  output logic             SYNC,
  output logic             ERR,
  output logic [2:0]       ERR_TIPO,
  output logic             ERR_STICKY,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [15:0]      CHK_CNT,
  output logic [WIDTH-1:0] Q_ESP
);

  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH:0]   PASO_EXT = (WIDTH + 1)'(PASO3);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [15:0]      CHK_MAX  = 16'hFFFF;

  typedef enum logic {UNSYNC, SYNCED} state_t;

  state_t           state;
  logic             enb_s;
  logic [1:0]       modo_s;
  logic [WIDTH-1:0] d_s;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] q_pred;
  logic             rco_pred;
  logic [WIDTH:0]   sum_paso;
  logic [2:0]       tipo_next;
  logic             err_next;
  logic             checking;

  assign checking = (state == SYNCED);
  assign err_next = |tipo_next;

  // Capture the counter's controls and current Q; the next prediction uses these.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      enb_s  <= 1'b0;
      modo_s <= 2'b00;
      d_s    <= '0;
      q_s    <= '0;
    end else begin
      enb_s  <= ENB;
      modo_s <= MODO;
      d_s    <= D;
      q_s    <= Q;
    end
  end

  // Reference counter: next Q/RCO from the observed Q, so one glitch never cascades.
  always_comb begin
    sum_paso = {1'b0, q_s} + PASO_EXT;
    q_pred   = q_s;
    rco_pred = 1'b0;
    if (enb_s) begin
      case (modo_s)
        2'b00: begin
          q_pred   = q_s + ONE_W;
          rco_pred = &q_s;
        end
        2'b01: begin
          q_pred   = q_s - ONE_W;
          rco_pred = ~|q_s;
        end
        2'b10: begin
          q_pred   = sum_paso[WIDTH-1:0];
          rco_pred = sum_paso[WIDTH];
        end
        default: begin
          q_pred   = d_s;
          rco_pred = 1'b0;
        end
      endcase
    end
  end

  // Mismatch classification: Q/RCO only once locked, parity on every sample.
  always_comb begin
    tipo_next    = 3'b000;
    tipo_next[0] = checking && (Q != q_pred);
    tipo_next[1] = checking && (RCO != rco_pred);
    tipo_next[2] = (Paridad != ^Q);
  end

  // Lock FSM plus the registered per-comparison outputs.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state    <= UNSYNC;
      SYNC     <= 1'b0;
      ERR      <= 1'b0;
      ERR_TIPO <= 3'b000;
      Q_ESP    <= '0;
    end else begin
      ERR      <= err_next;
      ERR_TIPO <= tipo_next;
      case (state)
        UNSYNC: begin
          if (ENB && (MODO == 2'b11)) begin
            state <= SYNCED;
            SYNC  <= 1'b1;
          end
        end
        default: begin
          Q_ESP <= q_pred;
        end
      endcase
    end
  end

  // Saturating statistics; a clear wins over any increment in the same cycle.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      ERR_CNT    <= '0;
      CHK_CNT    <= '0;
      ERR_STICKY <= 1'b0;
    end else if (CLR) begin
      ERR_CNT    <= '0;
      CHK_CNT    <= '0;
      ERR_STICKY <= 1'b0;
    end else begin
      if (err_next) begin
        ERR_STICKY <= 1'b1;
        if (ERR_CNT != ERR_MAX) begin
          ERR_CNT <= ERR_CNT + ERR_ONE;
        end
      end
      if (checking && (CHK_CNT != CHK_MAX)) begin
        CHK_CNT <= CHK_CNT + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_contador_monitor.sv
// tb_contador_monitor: drives an emulated counter (with fault injection) into
// the monitor and compares every output against a behavioural model.
module tb_contador_monitor;

  logic        clk;
  logic        resetL;
  logic        clr;
  logic        enb;
  logic [1:0]  modo;
  logic [15:0] d;
  logic [15:0] q;
  logic        rco;
  logic        paridad;
  logic        syncOut;
  logic        err;
  logic [2:0]  errTipo;
  logic        errSticky;
  logic [7:0]  errCnt;
  logic [15:0] chkCnt;
  logic [15:0] qEsp;

  int checks = 0;
  int errors = 0;

  // Emulated counter state
  int cnt    = 0;
  int cntRco = 0;

  // Behavioural model of the monitor
  int mPrevQ, mPrevD, mPrevEnb, mPrevModo;
  int mSync, mChk, mErrs, mSticky, mQesp, mTipo;

  contador_monitor #(.WIDTH(16), .PASO3(3), .ERR_W(8)) dut (
    .CLK(clk), .RESET_L(resetL), .CLR(clr), .ENB(enb), .MODO(modo), .D(d),
    .Q(q), .RCO(rco), .Paridad(paridad), .SYNC(syncOut), .ERR(err),
    .ERR_TIPO(errTipo), .ERR_STICKY(errSticky), .ERR_CNT(errCnt),
    .CHK_CNT(chkCnt), .Q_ESP(qEsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Counter contract with plain integer arithmetic
  function automatic void nextCount(input int cq, input int cenb, input int cmodo,
                                    input int cd, output int nq, output int nrco);
    nq = cq;
    nrco = 0;
    if (cenb != 0) begin
      case (cmodo)
        0: begin nq = (cq + 1) % 65536; nrco = (cq == 65535) ? 1 : 0; end
        1: begin nq = (cq == 0) ? 65535 : cq - 1; nrco = (cq == 0) ? 1 : 0; end
        2: begin nq = (cq + 3) % 65536; nrco = (cq + 3 > 65535) ? 1 : 0; end
        default: begin nq = cd; nrco = 0; end
      endcase
    end
  endfunction

  function automatic void modelReset();
    mPrevQ = 0; mPrevD = 0; mPrevEnb = 0; mPrevModo = 0;
    mSync = 0; mChk = 0; mErrs = 0; mSticky = 0; mQesp = 0; mTipo = 0;
  endfunction

  function automatic void modelEdge(input int sq, input int srco, input int spar,
                                    input int senb, input int smodo, input int sd,
                                    input int sclr);
    int pq, pr;
    nextCount(mPrevQ, mPrevEnb, mPrevModo, mPrevD, pq, pr);
    mTipo = 0;
    if (mSync != 0) begin
      if (sq != pq) mTipo += 1;
      if (srco != pr) mTipo += 2;
      mQesp = pq;
    end
    if (spar != ($countones(sq) % 2)) mTipo += 4;
    if (sclr != 0) begin
      mChk = 0; mErrs = 0; mSticky = 0;
    end else begin
      if (mSync != 0 && mChk < 65535) mChk++;
      if (mTipo != 0) begin
        mSticky = 1;
        if (mErrs < 255) mErrs++;
      end
    end
    if (senb != 0 && smodo == 3) mSync = 1;
    mPrevQ = sq; mPrevD = sd; mPrevEnb = senb; mPrevModo = smodo;
  endfunction

  task automatic compareAll();
    checkOutput("SYNC", 32'(syncOut), 32'(mSync));
    checkOutput("ERR", 32'(err), (mTipo != 0) ? 32'd1 : 32'd0);
    checkOutput("ERR_TIPO", 32'(errTipo), 32'(mTipo));
    checkOutput("ERR_STICKY", 32'(errSticky), 32'(mSticky));
    checkOutput("ERR_CNT", 32'(errCnt), 32'(mErrs));
    checkOutput("CHK_CNT", 32'(chkCnt), 32'(mChk));
    checkOutput("Q_ESP", 32'(qEsp), 32'(mQesp));
  endtask

  // One clock of stimulus: drive the counter's controls and (possibly faulty) outputs
  task automatic applyStimulus(input int senb, input int smodo, input int sd,
                               input int sclr, input int qFault, input int rFault,
                               input int pFault);
    int nq, nr;
    if (qFault != 0) cnt = (cnt + 2) % 65536;
    enb     = senb[0];
    modo    = smodo[1:0];
    d       = sd[15:0];
    clr     = sclr[0];
    q       = cnt[15:0];
    rco     = cntRco[0] ^ rFault[0];
    paridad = (^q) ^ pFault[0];
    @(posedge clk);
    #1;
    modelEdge(int'(q), int'(rco), int'(paridad), senb, smodo, sd, sclr);
    nextCount(cnt, senb, smodo, sd, nq, nr);
    cnt = nq;
    cntRco = nr;
    compareAll();
  endtask

  task automatic step(input int senb, input int smodo, input int sd);
    applyStimulus(senb, smodo, sd, 0, 0, 0, 0);
  endtask

  task automatic midReset();
    resetL = 1'b0;
    #1;
    modelReset();
    compareAll();
    #1;
    resetL = 1'b1;
  endtask

  initial begin
    int r;
    resetL = 1'b0; clr = 1'b0; enb = 1'b0; modo = 2'b00; d = '0;
    q = '0; rco = 1'b0; paridad = 1'b0;
    modelReset();
    #1;
    compareAll();
    #2;
    resetL = 1'b1;

    // Load 0 then count up
    step(1, 3, 0);
    checkOutput("sync_after_load", 32'(syncOut), 32'd1);
    for (int i = 0; i < 15; i++) step(1, 0, 0);
    step(0, 0, 0);
    checkOutput("count_up_chk", 32'(chkCnt), 32'd16);
    checkOutput("count_up_qesp", 32'(qEsp), 32'd15);
    checkOutput("count_up_errcnt", 32'(errCnt), 32'd0);

    // Load 120 then count down; then 0 down to FFFF
    step(1, 3, 120);
    for (int i = 0; i < 15; i++) step(1, 1, 0);
    step(0, 0, 0);
    checkOutput("count_down_qesp", 32'(qEsp), 32'd105);
    step(1, 3, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    checkOutput("down_wrap_qesp", 32'(qEsp), 32'hFFFF);
    checkOutput("down_wrap_err", 32'(err), 32'd0);

    // FFFE + 3 wraps with RCO; counter's RCO forced low
    step(1, 3, 16'hFFFE);
    step(1, 2, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("rco_fault_qesp", 32'(qEsp), 32'h0001);
    checkOutput("rco_fault_tipo", 32'(errTipo), 32'd2);
    checkOutput("rco_fault_cnt", 32'(errCnt), 32'd1);
    checkOutput("rco_fault_sticky", 32'(errSticky), 32'd1);
    step(1, 3, 16'hFFFC);
    step(1, 2, 0);
    step(0, 0, 0);
    checkOutput("paso_no_wrap_qesp", 32'(qEsp), 32'hFFFF);
    checkOutput("paso_no_wrap_err", 32'(err), 32'd0);

    // Single corrupted Q: one error only, then parity flip
    step(1, 3, 4);
    step(1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("q_glitch_tipo", 32'(errTipo), 32'd1);
    step(1, 0, 0);
    checkOutput("q_glitch_recover", 32'(errTipo), 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("par_flip_tipo", 32'(errTipo), 32'd4);

    // Hold at 1234, then CLR with three errors counted
    step(1, 3, 1234);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    checkOutput("hold_qesp", 32'(qEsp), 32'd1234);
    checkOutput("pre_clr_cnt", 32'(errCnt), 32'd3);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("clr_cnt", 32'(errCnt), 32'd0);
    checkOutput("clr_sticky", 32'(errSticky), 32'd0);
    checkOutput("clr_sync", 32'(syncOut), 32'd1);

    // Reset mid-count; no Q/RCO checks until the next load
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    midReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 1, 0);
    checkOutput("post_reset_chk", 32'(chkCnt), 32'd0);
    checkOutput("post_reset_errcnt", 32'(errCnt), 32'd0);

    // 300 consecutive parity faults saturate the error counter
    for (int i = 0; i < 300; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("err_saturate", 32'(errCnt), 32'hFF);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);

    // Randomized traffic with occasional faults, clears and one reset
    for (int i = 0; i < 400; i++) begin
      int rd, rm;
      rm = int'($urandom_range(0, 3));
      r  = int'($urandom_range(0, 4));
      rd = (r == 0) ? int'($urandom_range(65532, 65535)) :
           (r == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 65535));
      if (i == 200) midReset();
      applyStimulus(($urandom_range(0, 3) != 0) ? 1 : 0, rm, rd,
                    ($urandom_range(0, 29) == 0) ? 1 : 0,
                    ($urandom_range(0, 19) == 0) ? 1 : 0,
                    ($urandom_range(0, 19) == 0) ? 1 : 0,
                    ($urandom_range(0, 19) == 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
